clock_mode_ctrl: RTL and testbench



---
 rtl/clock_mode_ctrl_if.sv | 22 ++
 rtl/clock_mode_ctrl.sv | 139 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_mode_ctrl_if.sv
// Control/status bundle between the clock mode sequencer and its surroundings.
// The master side drives the user controls and the slave (sequencer) drives pulses and display state.
interface clock_mode_ctrl_if;
   logic       pause_btn;
   logic       adjust;
   logic       select;
   logic       sec_inc;
   logic       min_inc;
   logic [3:0] digit_on;
   logic [1:0] mode;
   logic       paused;

   modport master (
      output pause_btn, adjust, select,
      input  sec_inc, min_inc, digit_on, mode, paused
   );

   modport slave (
      input  pause_btn, adjust, select,
      output sec_inc, min_inc, digit_on, mode, paused
   );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the clock simulator: run / pause / adjust-minutes / adjust-seconds.
// Emits one-cycle increment pulses and a per-digit blink mask, all on the 4 Hz clock.
module clock_mode_ctrl #(
   parameter int unsigned RUN_DIV = 4,
   parameter int unsigned ADJ_DIV = 2,
   parameter int unsigned DIV_W   = 3
) (
   input  logic             clk4hz,
   input  logic             reset,
   clock_mode_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      PAUSED  = 2'b01,
      ADJ_MIN = 2'b10,
      ADJ_SEC = 2'b11
   } mode_t;

   localparam logic [DIV_W-1:0] RUN_LAST = DIV_W'(RUN_DIV - 1);
   localparam logic [DIV_W-1:0] ADJ_LAST = DIV_W'(ADJ_DIV - 1);

   logic             r_pause_s1, r_pause_s2, r_pause_prev;
   logic             r_adjust_s1, r_adjust_s2;
   logic             r_select_s1, r_select_s2;
   mode_t            r_mode;
   logic             r_paused;
   logic             r_sec_inc;
   logic             r_min_inc;
   logic             r_blink;
   logic [3:0]       r_digit_on;
   logic [DIV_W-1:0] r_presc;

   logic             w_pause_rise;
   logic             w_paused_nxt;
   mode_t            w_mode_nxt;
   logic             w_mode_chg;
   logic [DIV_W-1:0] w_presc_nxt;
   logic             w_blink_nxt;
   logic             w_sec_nxt;
   logic             w_min_nxt;
   logic [3:0]       w_digit_nxt;

   // A pause press is ignored while adjusting; the flag itself survives adjust entry/exit.
   always_comb begin
      w_pause_rise = r_pause_s2 & ~r_pause_prev;
      w_paused_nxt = r_paused ^ (w_pause_rise & ~r_adjust_s2);
      if (r_adjust_s2) begin
         w_mode_nxt = r_select_s2 ? ADJ_SEC : ADJ_MIN;
      end else begin
         w_mode_nxt = w_paused_nxt ? PAUSED : RUN;
      end
      w_mode_chg = (w_mode_nxt != r_mode);
   end

   always_comb begin
      w_presc_nxt = r_presc;
      w_blink_nxt = 1'b1;
      w_sec_nxt   = 1'b0;
      w_min_nxt   = 1'b0;
      if (w_mode_chg) begin
         w_presc_nxt = '0;
      end else begin
         case (r_mode)
            RUN: begin
               if (r_presc == RUN_LAST) begin
                  w_presc_nxt = '0;
                  w_sec_nxt   = 1'b1;
               end else begin
                  w_presc_nxt = r_presc + DIV_W'(1);
               end
            end
            PAUSED: begin
               w_presc_nxt = r_presc;
            end
            ADJ_MIN, ADJ_SEC: begin
               w_blink_nxt = ~r_blink;
               if (r_presc == ADJ_LAST) begin
                  w_presc_nxt = '0;
                  w_sec_nxt   = (r_mode == ADJ_SEC);
                  w_min_nxt   = (r_mode == ADJ_MIN);
               end else begin
                  w_presc_nxt = r_presc + DIV_W'(1);
               end
            end
            default: w_presc_nxt = '0;
         endcase
      end
   end

   always_comb begin
      case (w_mode_nxt)
         ADJ_MIN: w_digit_nxt = {w_blink_nxt, w_blink_nxt, 2'b11};
         ADJ_SEC: w_digit_nxt = {2'b11, w_blink_nxt, w_blink_nxt};
         default: w_digit_nxt = '1;
      endcase
   end

   always_ff @(posedge clk4hz) begin
      if (reset) begin
         r_pause_s1   <= 1'b0;
         r_pause_s2   <= 1'b0;
         r_pause_prev <= 1'b0;
         r_adjust_s1  <= 1'b0;
         r_adjust_s2  <= 1'b0;
         r_select_s1  <= 1'b0;
         r_select_s2  <= 1'b0;
         r_mode       <= RUN;
         r_paused     <= 1'b0;
         r_sec_inc    <= 1'b0;
         r_min_inc    <= 1'b0;
         r_blink      <= 1'b1;
         r_digit_on   <= '1;
         r_presc      <= '0;
      end else begin
         r_pause_s1   <= bus.pause_btn;
         r_pause_s2   <= r_pause_s1;
         r_pause_prev <= r_pause_s2;
         r_adjust_s1  <= bus.adjust;
         r_adjust_s2  <= r_adjust_s1;
         r_select_s1  <= bus.select;
         r_select_s2  <= r_select_s1;
         r_mode       <= w_mode_nxt;
         r_paused     <= w_paused_nxt;
         r_sec_inc    <= w_sec_nxt;
         r_min_inc    <= w_min_nxt;
         r_blink      <= w_blink_nxt;
         r_digit_on   <= w_digit_nxt;
         r_presc      <= w_presc_nxt;
      end
   end

   assign bus.sec_inc  = r_sec_inc;
   assign bus.min_inc  = r_min_inc;
   assign bus.digit_on = r_digit_on;
   assign bus.mode     = r_mode;
   assign bus.paused   = r_paused;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: expected per-edge outputs are queued as stimulus is
// applied and popped one per rising edge for comparison.
module tb_clock_mode_ctrl;

   localparam logic [1:0] M_RUN = 2'b00;
   localparam logic [1:0] M_PAU = 2'b01;
   localparam logic [1:0] M_MIN = 2'b10;
   localparam logic [1:0] M_SEC = 2'b11;

   typedef struct packed {
      logic [1:0] mode;
      logic       paused;
      logic       sec;
      logic       min;
      logic [3:0] dig;
   } obs_t;

   logic clk4hz = 1'b0;
   logic reset  = 1'b1;
   int unsigned checks   = 0;
   int unsigned failures = 0;
   obs_t sb[$];

   clock_mode_ctrl_if bus ();

   clock_mode_ctrl #(
      .RUN_DIV (4),
      .ADJ_DIV (2),
      .DIV_W   (3)
   ) dut (
      .clk4hz (clk4hz),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk4hz = ~clk4hz;

   function automatic obs_t mk(logic [1:0] m, logic p, logic s, logic mi, logic [3:0] d);
      obs_t o;
      o = {m, p, s, mi, d};
      return o;
   endfunction

   task automatic test_reset();
      obs_t exp, got;
      reset = 1'b1;
      bus.pause_btn = 1'b0;
      bus.adjust    = 1'b0;
      bus.select    = 1'b0;
      for (int i = 0; i < 2; i++) sb.push_back(mk(M_RUN, 1'b0, 1'b0, 1'b0, 4'hF));
      for (int k = 1; k <= 12; k++) sb.push_back(mk(M_RUN, 1'b0, (k % 4 == 0), 1'b0, 4'hF));
      for (int i = 0; i < 14; i++) begin
         @(posedge clk4hz); #1;
         exp = sb.pop_front();
         got = {bus.mode, bus.paused, bus.sec_inc, bus.min_inc, bus.digit_on};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_run step=%0d got=%b exp=%b (mode,paused,sec,min,digits)", i, got, exp);
         end
         if (i == 1) reset = 1'b0;
      end
   endtask

   task automatic test_pause();
      obs_t exp, got;
      for (int i = 0; i < 19; i++) begin
         if (i < 2)       sb.push_back(mk(M_RUN, 1'b0, 1'b0, 1'b0, 4'hF));
         else if (i < 10) sb.push_back(mk(M_PAU, 1'b1, 1'b0, 1'b0, 4'hF));
         else             sb.push_back(mk(M_RUN, 1'b0, (i == 14 || i == 18), 1'b0, 4'hF));
      end
      bus.pause_btn = 1'b1;
      for (int i = 0; i < 19; i++) begin
         @(posedge clk4hz); #1;
         exp = sb.pop_front();
         got = {bus.mode, bus.paused, bus.sec_inc, bus.min_inc, bus.digit_on};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL pause_toggle step=%0d got=%b exp=%b (mode,paused,sec,min,digits)", i, got, exp);
         end
         if (i == 0 || i == 8) bus.pause_btn = 1'b0;
         if (i == 7) bus.pause_btn = 1'b1;
      end
   endtask

   task automatic test_adjust_min();
      obs_t exp, got;
      int k;
      for (int i = 0; i < 10; i++) begin
         k = i - 2;
         if (i < 2) sb.push_back(mk(M_RUN, 1'b0, 1'b0, 1'b0, 4'hF));
         else       sb.push_back(mk(M_MIN, 1'b0, 1'b0, (k > 0 && k % 2 == 0),
                                    (k % 2 == 0) ? 4'hF : 4'b0011));
      end
      bus.adjust = 1'b1;
      bus.select = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk4hz); #1;
         exp = sb.pop_front();
         got = {bus.mode, bus.paused, bus.sec_inc, bus.min_inc, bus.digit_on};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL adjust_min step=%0d got=%b exp=%b (mode,paused,sec,min,digits)", i, got, exp);
         end
      end
   endtask

   task automatic test_select_flip();
      obs_t exp, got;
      int k;
      sb.push_back(mk(M_MIN, 1'b0, 1'b0, 1'b1, 4'hF));
      sb.push_back(mk(M_MIN, 1'b0, 1'b0, 1'b0, 4'b0011));
      for (int i = 2; i < 9; i++) begin
         k = i - 2;
         sb.push_back(mk(M_SEC, 1'b0, (k > 0 && k % 2 == 0), 1'b0,
                         (k % 2 == 0) ? 4'hF : 4'b1100));
      end
      bus.select = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk4hz); #1;
         exp = sb.pop_front();
         got = {bus.mode, bus.paused, bus.sec_inc, bus.min_inc, bus.digit_on};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL select_flip step=%0d got=%b exp=%b (mode,paused,sec,min,digits)", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_adjust();
      obs_t exp, got;
      sb.push_back(mk(M_RUN, 1'b0, 1'b0, 1'b0, 4'hF));
      for (int k = 1; k <= 4; k++) sb.push_back(mk(M_RUN, 1'b0, (k == 4), 1'b0, 4'hF));
      reset      = 1'b1;
      bus.adjust = 1'b0;
      bus.select = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk4hz); #1;
         exp = sb.pop_front();
         got = {bus.mode, bus.paused, bus.sec_inc, bus.min_inc, bus.digit_on};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_mid_adjust step=%0d got=%b exp=%b (mode,paused,sec,min,digits)", i, got, exp);
         end
         if (i == 0) reset = 1'b0;
      end
   endtask

   // Enter adjust while paused, press pause inside adjust, then leave adjust.
   task automatic test_adjust_pause();
      obs_t exp, got;
      int k;
      for (int i = 0; i < 16; i++) begin
         k = i - 5;
         if (i < 2)       sb.push_back(mk(M_RUN, 1'b0, 1'b0, 1'b0, 4'hF));
         else if (i < 5)  sb.push_back(mk(M_PAU, 1'b1, 1'b0, 1'b0, 4'hF));
         else if (i < 13) sb.push_back(mk(M_MIN, 1'b1, 1'b0, (k > 0 && k % 2 == 0),
                                          (k % 2 == 0) ? 4'hF : 4'b0011));
         else             sb.push_back(mk(M_PAU, 1'b1, 1'b0, 1'b0, 4'hF));
      end
      bus.pause_btn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk4hz); #1;
         exp = sb.pop_front();
         got = {bus.mode, bus.paused, bus.sec_inc, bus.min_inc, bus.digit_on};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL adjust_pause step=%0d got=%b exp=%b (mode,paused,sec,min,digits)", i, got, exp);
         end
         if (i == 0 || i == 6) bus.pause_btn = 1'b0;
         if (i == 2) begin
            bus.adjust = 1'b1;
            bus.select = 1'b0;
         end
         if (i == 5)  bus.pause_btn = 1'b1;
         if (i == 10) bus.adjust = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_pause();
      test_adjust_min();
      test_select_flip();
      test_reset_mid_adjust();
      test_adjust_pause();
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time_limit_reached");
      $fatal(1);
   end

endmodule
